// File: rtl/rx_cmd_pkg.sv
// Shared constants, state/command enums and the case-fold helper for rx_cmd_parser.
// Optional feature macro: RX_CMD_CASEFOLD_EN.
package rx_cmd_pkg;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [7:0] ASCII_9     = 8'h39;

    // Command strings, right-aligned: the first character is the most significant used byte.
    localparam logic [47:0] STR_INIT  = {16'h0000, "init"};
    localparam logic [47:0] STR_NORM  = {16'h0000, "norm"};
    localparam logic [47:0] STR_START = {8'h00, "start"};
    localparam logic [47:0] STR_STOP  = {16'h0000, "stop"};
    localparam logic [47:0] STR_RATE  = {8'h00, "rate", ASCII_COLON};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DISCARD,
        ST_EXEC
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_INIT,
        CMD_NORMAL,
        CMD_START,
        CMD_FINISH,
        CMD_RATE,
        CMD_ERR
    } cmd_e;

    // Character k (0 = first) of an n-character string constant; zero past the end.
    function automatic logic [7:0] str_byte(input logic [47:0] s, input int unsigned n,
                                            input int unsigned k);
        logic [47:0] sh;
        sh = (k < n) ? (s >> (8 * (n - 1 - k))) : '0;
        return sh[7:0];
    endfunction

`ifdef RX_CMD_CASEFOLD_EN
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
    endfunction
`endif

endpackage

// File: rtl/rx_cmd_parser_if.sv
// Byte input and decoded-command output bundle of rx_cmd_parser.
interface rx_cmd_parser_if;

    logic [7:0] iRX_DATA;
    logic       iRX_VALID;
    logic [7:0] oRATE;
    logic       oRATE_UPD;
    logic       oCMD_INIT;
    logic       oCMD_NORMAL;
    logic       oCMD_START;
    logic       oCMD_FINISH;
    logic       oCMD_ERR;
    logic       oBUSY;

    modport master (
        output iRX_DATA, iRX_VALID,
        input  oRATE, oRATE_UPD, oCMD_INIT, oCMD_NORMAL, oCMD_START, oCMD_FINISH,
               oCMD_ERR, oBUSY
    );

    modport slave (
        input  iRX_DATA, iRX_VALID,
        output oRATE, oRATE_UPD, oCMD_INIT, oCMD_NORMAL, oCMD_START, oCMD_FINISH,
               oCMD_ERR, oBUSY
    );

endinterface

// File: rtl/rx_cmd_parser_decode.sv
// Combinational matcher: line buffer + length + error flag -> command code and rate digit.
module rx_cmd_decode
    import rx_cmd_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0][7:0] i_buf,
    input  logic [LEN_W-1:0]        i_len,
    input  logic                    i_err,
    output cmd_e                    o_cmd,
    output logic [7:0]              o_rate
);

    logic [MAX_LEN-1:0] w_ok_init;
    logic [MAX_LEN-1:0] w_ok_norm;
    logic [MAX_LEN-1:0] w_ok_start;
    logic [MAX_LEN-1:0] w_ok_stop;
    logic [MAX_LEN-1:0] w_ok_rate;
    logic [7:0]         w_digit;

    // Positions at or beyond len are don't-care; the length compare below enforces exactness.
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_cmp
        localparam logic [LEN_W-1:0] POS = LEN_W'(g);
        assign w_ok_init[g]  = (POS >= i_len) || (i_buf[g] == str_byte(STR_INIT, 4, g));
        assign w_ok_norm[g]  = (POS >= i_len) || (i_buf[g] == str_byte(STR_NORM, 4, g));
        assign w_ok_start[g] = (POS >= i_len) || (i_buf[g] == str_byte(STR_START, 5, g));
        assign w_ok_stop[g]  = (POS >= i_len) || (i_buf[g] == str_byte(STR_STOP, 4, g));
        assign w_ok_rate[g]  = (POS >= i_len) || (g == 5) ||
                               (i_buf[g] == str_byte(STR_RATE, 5, g));
    end

    if (MAX_LEN >= 6) begin : g_digit
        assign w_digit = i_buf[5];
    end else begin : g_no_digit
        assign w_digit = '0;
    end

    always_comb begin
        o_cmd  = CMD_ERR;
        o_rate = w_digit;
        if (!i_err) begin
            if (i_len == LEN_W'(4) && (&w_ok_init))
                o_cmd = CMD_INIT;
            else if (i_len == LEN_W'(4) && (&w_ok_norm))
                o_cmd = CMD_NORMAL;
            else if (i_len == LEN_W'(5) && (&w_ok_start))
                o_cmd = CMD_START;
            else if (i_len == LEN_W'(4) && (&w_ok_stop))
                o_cmd = CMD_FINISH;
            else if (i_len == LEN_W'(6) && (&w_ok_rate) &&
                     w_digit >= ASCII_1 && w_digit <= ASCII_9)
                o_cmd = CMD_RATE;
        end
    end

endmodule

// File: rtl/rx_cmd_parser.sv
// UART RX command-line parser: collects LF-terminated lines and emits command strobes.
// Optional feature macro: RX_CMD_CASEFOLD_EN (fold 'A'..'Z' to lowercase before storage).
module rx_cmd_parser
    import rx_cmd_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 8,
    parameter logic [7:0]  RATE_RST = 8'h31
) (
    input  logic           clk,
    input  logic           reset,
    rx_cmd_parser_if.slave bus
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e                  r_state;
    logic [LEN_W-1:0]        r_len;
    logic [MAX_LEN-1:0][7:0] r_buf;
    logic                    r_err;
    cmd_e                    r_cmd;
    logic [7:0]              r_digit;
    logic [7:0]              r_rate;
    logic                    r_rate_upd;
    logic                    r_init;
    logic                    r_norm;
    logic                    r_start;
    logic                    r_finish;
    logic                    r_cmd_err;

    logic [7:0]              w_char;
    logic                    w_is_lf;
    logic                    w_is_chr;
    cmd_e                    w_cmd;
    logic [7:0]              w_digit;

`ifdef RX_CMD_CASEFOLD_EN
    assign w_char = fold_case(bus.iRX_DATA);
`else
    assign w_char = bus.iRX_DATA;
`endif

    assign w_is_lf  = bus.iRX_VALID && (bus.iRX_DATA == ASCII_LF);
    assign w_is_chr = bus.iRX_VALID && (bus.iRX_DATA != ASCII_LF) &&
                      (bus.iRX_DATA != ASCII_CR);

    rx_cmd_decode #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_decode (
        .i_buf  (r_buf),
        .i_len  (r_len),
        .i_err  (r_err),
        .o_cmd  (w_cmd),
        .o_rate (w_digit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_buf   <= '0;
            r_err   <= 1'b0;
            r_cmd   <= CMD_NONE;
            r_digit <= '0;
        end else begin
            r_cmd <= CMD_NONE;
            case (r_state)
                // EXEC behaves like IDLE for the incoming byte so nothing is dropped.
                ST_IDLE, ST_EXEC: begin
                    if (r_state == ST_EXEC) begin
                        r_cmd   <= w_cmd;
                        r_digit <= w_digit;
                    end
                    r_err   <= 1'b0;
                    r_len   <= '0;
                    r_state <= ST_IDLE;
                    if (w_is_chr) begin
                        r_buf[0] <= w_char;
                        r_len    <= LEN_W'(1);
                        r_state  <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_is_lf) begin
                        r_state <= ST_EXEC;
                    end else if (w_is_chr) begin
                        if (r_len == LEN_W'(MAX_LEN)) begin
                            r_state <= ST_DISCARD;
                            r_err   <= 1'b1;
                        end else begin
                            r_buf[r_len[IDX_W-1:0]] <= w_char;
                            r_len                   <= r_len + 1'b1;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (w_is_lf)
                        r_state <= ST_EXEC;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output stage: one registered strobe per decoded command, two edges after the LF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rate     <= RATE_RST;
            r_rate_upd <= 1'b0;
            r_init     <= 1'b0;
            r_norm     <= 1'b0;
            r_start    <= 1'b0;
            r_finish   <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_rate_upd <= (r_cmd == CMD_RATE);
            r_init     <= (r_cmd == CMD_INIT);
            r_norm     <= (r_cmd == CMD_NORMAL);
            r_start    <= (r_cmd == CMD_START);
            r_finish   <= (r_cmd == CMD_FINISH);
            r_cmd_err  <= (r_cmd == CMD_ERR);
            if (r_cmd == CMD_RATE)
                r_rate <= r_digit;
        end
    end

    assign bus.oRATE       = r_rate;
    assign bus.oRATE_UPD   = r_rate_upd;
    assign bus.oCMD_INIT   = r_init;
    assign bus.oCMD_NORMAL = r_norm;
    assign bus.oCMD_START  = r_start;
    assign bus.oCMD_FINISH = r_finish;
    assign bus.oCMD_ERR    = r_cmd_err;
    assign bus.oBUSY       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Directed self-checking bench for rx_cmd_parser: command lines in, strobe timing/values out.
module tb_rx_cmd_parser;

    localparam logic [5:0] V_INIT   = 6'b100000;
    localparam logic [5:0] V_NORM   = 6'b010000;
    localparam logic [5:0] V_START  = 6'b001000;
    localparam logic [5:0] V_FINISH = 6'b000100;
    localparam logic [5:0] V_RATE   = 6'b000010;
    localparam logic [5:0] V_ERR    = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] v;
        logic [7:0] rate;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    ev_t  ev_q[$];
    int   lf_q[$];
    logic [5:0] w_stb;

    always #5 clk = ~clk;

    rx_cmd_parser_if bus ();

    rx_cmd_parser #(
        .MAX_LEN  (8),
        .RATE_RST (8'h31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign w_stb = {bus.oCMD_INIT, bus.oCMD_NORMAL, bus.oCMD_START, bus.oCMD_FINISH,
                    bus.oRATE_UPD, bus.oCMD_ERR};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (w_stb != 6'b0)
            ev_q.push_back('{cyc, w_stb, bus.oRATE});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.iRX_VALID = 1'b1;
            bus.iRX_DATA  = s[i];
            if (s[i] == 8'h0A)
                lf_q.push_back(cyc);
        end
        @(negedge clk);
        bus.iRX_VALID = 1'b0;
        bus.iRX_DATA  = 8'h00;
    endtask

    task automatic begin_scn();
        ev_q.delete();
        lf_q.delete();
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic expect_ev(input string tag, input logic [5:0] v, input logic [7:0] rate);
        int  lf;
        ev_t e;
        check({tag, " lf sent"}, 32'(lf_q.size() > 0), 32'd1);
        if (lf_q.size() == 0)
            return;
        lf = lf_q.pop_front();
        check({tag, " pulse seen"}, 32'(ev_q.size() > 0), 32'd1);
        if (ev_q.size() == 0)
            return;
        e = ev_q.pop_front();
        check({tag, " strobes"}, 32'(e.v), 32'(v));
        check({tag, " latency"}, 32'(e.cyc - lf), 32'd3);
        check({tag, " rate"}, 32'(e.rate), 32'(rate));
    endtask

    task automatic expect_quiet(input string tag);
        check({tag, " extra pulses"}, 32'(ev_q.size()), 32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.iRX_VALID = 1'b0;
        bus.iRX_DATA  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst rate", 32'(bus.oRATE), 32'h31);
        check("rst strobes", 32'(w_stb), 32'd0);
        check("rst busy", 32'(bus.oBUSY), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        begin_scn();
        send("init\n");
        settle();
        expect_ev("init", V_INIT, 8'h31);
        expect_quiet("init");

        begin_scn();
        send("rate:7\r\n");
        settle();
        expect_ev("rate7", V_RATE, 8'h37);
        expect_quiet("rate7");
        send("rate:0\n");
        settle();
        expect_ev("rate0", V_ERR, 8'h37);
        expect_quiet("rate0");
        check("rate0 held", 32'(bus.oRATE), 32'h37);

        begin_scn();
        send("abcdefghij");
        check("ovl busy discard", 32'(bus.oBUSY), 32'd1);
        send("\n");
        check("ovl busy exec", 32'(bus.oBUSY), 32'd1);
        @(negedge clk);
        check("ovl idle", 32'(bus.oBUSY), 32'd0);
        send("stop\n");
        settle();
        expect_ev("ovl err", V_ERR, 8'h37);
        expect_ev("ovl stop", V_FINISH, 8'h37);
        expect_quiet("ovl");

        begin_scn();
        send("start\nstop\n");
        settle();
        expect_ev("b2b start", V_START, 8'h37);
        expect_ev("b2b stop", V_FINISH, 8'h37);
        expect_quiet("b2b");

        begin_scn();
        send("rat");
        check("mid busy", 32'(bus.oBUSY), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async rate", 32'(bus.oRATE), 32'h31);
        check("async strobes", 32'(w_stb), 32'd0);
        check("async busy", 32'(bus.oBUSY), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send("\n");
        settle();
        expect_quiet("post reset");
        check("post reset rate", 32'(bus.oRATE), 32'h31);

        begin_scn();
        send("NORM\n");
        settle();
`ifdef RX_CMD_CASEFOLD_EN
        expect_ev("upper", V_NORM, 8'h31);
`else
        expect_ev("upper", V_ERR, 8'h31);
`endif
        expect_quiet("upper");

        begin_scn();
        send("norm\nrate:9\nrate:12\nrate:\n");
        settle();
        expect_ev("norm", V_NORM, 8'h31);
        expect_ev("rate9", V_RATE, 8'h39);
        expect_ev("rate12", V_ERR, 8'h39);
        expect_ev("rate empty", V_ERR, 8'h39);
        expect_quiet("mix");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_cmd_parser.md
# rx_cmd_parser

UART receive-side command parser: the counterpart of the transmit-side status-text generator. It takes bytes from the UART receiver, assembles newline-terminated ASCII command lines, and decodes them into single-cycle control strobes and a rate register. It sits between the UART RX core and the mode-control FSM, which consumes its INIT/NORMAL/START/FINISH strobes and the ASCII rate digit.

## Interface
Parameters:
- MAX_LEN, 8: maximum characters per line, excluding terminator; sets line-buffer depth.
- RATE_RST, 8'h31: reset value of oRATE (ASCII '1').

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- iRX_DATA  input  8  received byte; valid only when iRX_VALID=1.
- iRX_VALID  input  1  one-cycle strobe per received byte.
- oRATE  output  8  current rate as an ASCII digit '1'..'9'; reset RATE_RST.
- oRATE_UPD  output  1  one-cycle pulse when oRATE is written; reset 0.
- oCMD_INIT  output  1  one-cycle pulse for "init"; reset 0.
- oCMD_NORMAL  output  1  one-cycle pulse for "norm"; reset 0.
- oCMD_START  output  1  one-cycle pulse for "start"; reset 0.
- oCMD_FINISH  output  1  one-cycle pulse for "stop"; reset 0.
- oCMD_ERR  output  1  one-cycle pulse for a malformed, unknown or overlong line; reset 0.
- oBUSY  output  1  high while a line is partly collected, in DISCARD, or in EXEC; reset 0.

## Operation
- Byte classes:
  - LF (0x0A) terminates a line.
  - CR (0x0D) is ignored in every state.
  - Every other byte is a line character.
- States: IDLE, COLLECT, DISCARD, EXEC. Reset state is IDLE, with the length counter and buffer cleared.
- IDLE:
  - A character goes to buffer[0], len=1, next state COLLECT.
  - LF is an empty line: stay in IDLE, no pulse.
- COLLECT:
  - A character while len<MAX_LEN goes to buffer[len], len+1.
  - A character while len==MAX_LEN goes to DISCARD.
  - LF goes to EXEC.
- DISCARD: drop all characters. LF goes to EXEC with the error flag set.
- EXEC lasts one cycle:
  - Compare the buffer with len.
  - Go to IDLE and clear len.
  - Exactly one output pulse is asserted.
- Command set (exact match, length included):
  - "init" pulses oCMD_INIT.
  - "norm" pulses oCMD_NORMAL.
  - "start" pulses oCMD_START.
  - "stop" pulses oCMD_FINISH.
  - "rate:D", where D is '1'..'9': oRATE<=D and pulse oRATE_UPD.
  - "rate:" with any other D, any other text, or the error flag: pulse oCMD_ERR. oRATE is unchanged.
- A byte with iRX_VALID=1 during EXEC is not lost. It is processed as if received in IDLE, so a character becomes buffer[0] of the next line.
- Pulses never overlap. At most one strobe is high in any cycle.
- len is $clog2(MAX_LEN+1) bits and never wraps. The overflow check uses len==MAX_LEN.

## Timing
- The LF is accepted at edge N.
- The state is EXEC during cycle N..N+1.
- The command pulse is registered and high for exactly the cycle following edge N+2 (latency 2 edges from LF).
- oRATE changes at the same edge its oRATE_UPD pulse rises.
- Back-to-back bytes on consecutive cycles are accepted with no backpressure.
- Reset asserted mid-line:
  - All outputs return to their reset values immediately (asynchronous).
  - The partial line is discarded.
  - No pulse is produced after release.

## Configuration
- RX_CMD_CASEFOLD_EN:
  - Defined: bytes 'A'..'Z' are folded to lowercase before storage, so "INIT" and "Rate:5" are accepted.
  - Undefined: matching is case-sensitive, and uppercase lines produce oCMD_ERR.
- Fold logic is absent from the netlist when the macro is undefined.

## Structure
- Package rx_cmd_pkg holds:
  - ASCII constants: LF, CR, ':', '1', '9', plus the command strings as byte constants.
  - The state enum.
  - The command-code enum: NONE, INIT, NORMAL, START, FINISH, RATE, ERR.
- Sub-module rx_cmd_decode is combinational. It takes the buffer, len and error flag, and returns the command code and rate digit. The parent registers its result into the pulses.

## Test plan
- Bytes "init\n" on consecutive cycles -> oCMD_INIT high exactly 1 cycle, 2 edges after the LF; all other strobes stay 0.
- "rate:7\r\n" -> oRATE=8'h37 and oRATE_UPD pulse. Then "rate:0\n" -> oCMD_ERR pulse, oRATE stays 8'h37.
- "abcdefghij\n" (10 chars) -> oBUSY stays high until EXEC, then a single oCMD_ERR. A following "stop\n" -> oCMD_FINISH.
- "start\n" with 's' of the next "stop\n" presented in the EXEC cycle -> oCMD_START, then oCMD_FINISH; no byte is lost.
- Reset pulsed after "rat" -> oRATE=8'h31, every output 0. Then "\n" -> no pulse.
- "NORM\n" -> oCMD_NORMAL with RX_CMD_CASEFOLD_EN defined; oCMD_ERR without it.
